// File: rtl/dbg_uart_wb_pkg.sv
// rtl/dbg_uart_wb_pkg.sv - shared state encoding and protocol constants for the UART debug bus master
package dbg_uart_wb_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SIZE  = 3'd1,
      ADDR  = 3'd2,
      WDATA = 3'd3,
      WB_WR = 3'd4,
      WB_RD = 3'd5,
      TX    = 3'd6
   } state_t;

   localparam logic [7:0]  CMD_WRITE     = 8'h01;
   localparam logic [7:0]  CMD_READ      = 8'h02;
   localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/dbg_byte_pack.sv
// rtl/dbg_byte_pack.sv - 4-byte big-endian shift-in/shift-out word register with byte counter
module dbg_byte_pack (
   input  logic        clk,
   input  logic        resetn,
   input  logic        i_clr,
   input  logic        i_load,
   input  logic [31:0] i_word,
   input  logic        i_shift_in,
   input  logic [7:0]  i_byte,
   input  logic        i_shift_out,
   output logic [31:0] o_word,
   output logic [1:0]  o_cnt
);

   logic [31:0] r_word;
   logic [1:0]  r_cnt;

   // Load wins over shifting so a bus completion can never be merged with a byte move.
   always_ff @(posedge clk) begin
      if (!resetn || i_clr) begin
         r_word <= 32'h0;
         r_cnt  <= 2'd0;
      end else if (i_load) begin
         r_word <= i_word;
         r_cnt  <= 2'd0;
      end else if (i_shift_in) begin
         r_word <= {r_word[23:0], i_byte};
         r_cnt  <= r_cnt + 2'd1;
      end else if (i_shift_out) begin
         r_word <= {r_word[23:0], 8'h00};
         r_cnt  <= r_cnt + 2'd1;
      end
   end

   assign o_word = r_word;
   assign o_cnt  = r_cnt;

endmodule

// File: rtl/dbg_uart_wb_ctrl.sv
// rtl/dbg_uart_wb_ctrl.sv - UART debug command sequencer acting as a Wishbone classic master
// Optional ack timeout enabled by defining DBG_WB_TIMEOUT_EN.
module dbg_uart_wb_ctrl
   import dbg_uart_wb_pkg::*;
#(
   parameter logic [31:0] RX_GAP_CYCLES = 32'd200000
`ifdef DBG_WB_TIMEOUT_EN
   ,parameter logic [15:0] WB_TIMEOUT_CYCLES = 16'd1024
`endif
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_stb_o,
   output logic        wbm_cyc_o,
   input  logic        wbm_ack_i,
   output logic        busy,
   output logic        err
);

   state_t      r_state, w_next;
   logic [7:0]  r_words;
   logic        r_is_wr;
   logic [31:0] r_gap;
   logic        r_err;

   logic [31:0] w_adr, w_dat;
   logic [1:0]  w_adr_cnt, w_dat_cnt;
   logic        w_start, w_rx_st, w_gap_hit, w_cyc, w_to_hit, w_done, w_tx_fire;

   assign w_start   = (r_state == IDLE) && rx_valid &&
                      ((rx_data == CMD_WRITE) || (rx_data == CMD_READ));
   assign w_rx_st   = (r_state == SIZE) || (r_state == ADDR) || (r_state == WDATA);
   // A byte arriving on the limit cycle keeps the command alive.
   assign w_gap_hit = w_rx_st && !rx_valid && (r_gap >= RX_GAP_CYCLES - 32'd1);
   assign w_cyc     = (r_state == WB_WR) || (r_state == WB_RD);
   assign w_done    = w_cyc && (wbm_ack_i || w_to_hit);
   assign w_tx_fire = (r_state == TX) && tx_ready;

`ifdef DBG_WB_TIMEOUT_EN
   logic [15:0] r_to;

   assign w_to_hit = w_cyc && !wbm_ack_i && (r_to == WB_TIMEOUT_CYCLES - 16'd1);

   always_ff @(posedge clk) begin
      if (!resetn || !w_cyc || wbm_ack_i || w_to_hit) r_to <= 16'd0;
      else                                           r_to <= r_to + 16'd1;
   end
`else
   assign w_to_hit = 1'b0;
`endif

   dbg_byte_pack u_adr (
      .clk         (clk),
      .resetn      (resetn),
      .i_clr       (w_start),
      .i_load      (w_done),
      .i_word      (w_adr + 32'd4),
      .i_shift_in  ((r_state == ADDR) && rx_valid),
      .i_byte      (rx_data),
      .i_shift_out (1'b0),
      .o_word      (w_adr),
      .o_cnt       (w_adr_cnt)
   );

   dbg_byte_pack u_dat (
      .clk         (clk),
      .resetn      (resetn),
      .i_clr       (w_start),
      .i_load      ((r_state == WB_RD) && w_done),
      .i_word      (w_to_hit ? TIMEOUT_RDATA : wbm_dat_i),
      .i_shift_in  ((r_state == WDATA) && rx_valid),
      .i_byte      (rx_data),
      .i_shift_out (w_tx_fire),
      .o_word      (w_dat),
      .o_cnt       (w_dat_cnt)
   );

   always_ff @(posedge clk) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:  if (w_start) w_next = SIZE;
         SIZE:  begin
            if (rx_valid)       w_next = ADDR;
            else if (w_gap_hit) w_next = IDLE;
         end
         ADDR:  begin
            if (rx_valid && (w_adr_cnt == 2'd3)) begin
               if (r_words == 8'd0) w_next = IDLE;
               else if (r_is_wr)    w_next = WDATA;
               else                 w_next = WB_RD;
            end else if (w_gap_hit) begin
               w_next = IDLE;
            end
         end
         WDATA: begin
            if (rx_valid && (w_dat_cnt == 2'd3)) w_next = WB_WR;
            else if (w_gap_hit)                  w_next = IDLE;
         end
         WB_WR: if (w_done) w_next = (r_words == 8'd1) ? IDLE : WDATA;
         WB_RD: if (w_done) w_next = TX;
         TX:    if (w_tx_fire && (w_dat_cnt == 2'd3)) w_next = (r_words == 8'd0) ? IDLE : WB_RD;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      busy      = (r_state != IDLE);
      wbm_cyc_o = w_cyc;
      wbm_stb_o = w_cyc;
      wbm_we_o  = (r_state == WB_WR);
      wbm_sel_o = w_cyc ? 4'hF : 4'h0;
      wbm_adr_o = w_adr;
      wbm_dat_o = w_dat;
      tx_valid  = (r_state == TX);
      tx_data   = (r_state == TX) ? w_dat[31:24] : 8'h00;
      err       = r_err;
   end

   // r_words holds the words still to move; it drops at each bus completion.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_words <= 8'd0;
         r_is_wr <= 1'b0;
         r_gap   <= 32'd0;
         r_err   <= 1'b0;
      end else begin
         if (w_start)                          r_is_wr <= (rx_data == CMD_WRITE);
         if ((r_state == SIZE) && rx_valid)    r_words <= rx_data;
         else if (w_done)                      r_words <= r_words - 8'd1;
         if (w_rx_st && !rx_valid && !w_gap_hit) r_gap <= r_gap + 32'd1;
         else                                  r_gap <= 32'd0;
         if ((rx_valid && (w_cyc || (r_state == TX))) || w_gap_hit || w_to_hit)
            r_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dbg_uart_wb_ctrl.sv
// tb/tb_dbg_uart_wb_ctrl.sv - directed self-checking bench for dbg_uart_wb_ctrl
module tb_dbg_uart_wb_ctrl;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [31:0] wbm_adr_o, wbm_dat_o;
   logic [31:0] wbm_dat_i = 32'h0;
   logic        wbm_we_o, wbm_stb_o, wbm_cyc_o, busy, err;
   logic [3:0]  wbm_sel_o;
   logic        wbm_ack_i = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   logic        slave_en = 1'b1;
   int          wait_cnt = 0;
   int          n_log = 0;
   logic [31:0] log_adr [0:15];
   logic [31:0] log_dat [0:15];
   logic        log_we  [0:15];
   logic [3:0]  log_sel [0:15];
   logic [31:0] rd_q    [0:15];
   int          rd_i = 0;

   dbg_uart_wb_ctrl #(.RX_GAP_CYCLES(32'd40)) dut (
      .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
      .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_stb_o(wbm_stb_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_ack_i(wbm_ack_i), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Slave acks on the second cycle of each strobe and logs what it saw.
   always @(posedge clk) begin
      #1;
      if (wbm_ack_i) begin
         wbm_ack_i = 1'b0;
      end else if (wbm_cyc_o && wbm_stb_o && slave_en) begin
         if (wait_cnt == 1) begin
            wait_cnt = 0;
            wbm_ack_i = 1'b1;
            if (n_log < 16) begin
               log_adr[n_log] = wbm_adr_o;
               log_dat[n_log] = wbm_dat_o;
               log_we[n_log]  = wbm_we_o;
               log_sel[n_log] = wbm_sel_o;
            end
            n_log = n_log + 1;
            if (!wbm_we_o) begin
               wbm_dat_i = rd_q[rd_i];
               rd_i = rd_i + 1;
            end
         end else begin
            wait_cnt = wait_cnt + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      assert (obs === exp) else begin
         n_bad = n_bad + 1;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (busy && k < 3000) begin
         tick();
         k++;
      end
      chk(tag, {31'd0, busy}, 32'd0);
   endtask

   task automatic wait_cyc_done();
      int k = 0;
      while (!wbm_cyc_o && k < 100) begin tick(); k++; end
      while (wbm_cyc_o && k < 200) begin tick(); k++; end
   endtask

   task automatic recv(input string tag, input logic [7:0] exp, input int stall);
      int k = 0;
      while (!tx_valid && k < 3000) begin
         tick();
         k++;
      end
      chk({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
      chk(tag, {24'd0, tx_data}, {24'd0, exp});
      for (int s = 0; s < stall; s++) tick();
      if (stall > 0) begin
         chk({tag, "_held"}, {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, exp});
      end
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
   endtask

   initial begin
      repeat (3) tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_cyc", {28'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o, tx_valid}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_adr", wbm_adr_o, 32'd0);
      chk("rst_dat", wbm_dat_o, 32'd0);
      resetn = 1'b1;
      tick();

      // single-word write
      send(8'h01); send(8'h01); send(8'h00); send(8'h00); send(8'h01); send(8'h10);
      send(8'h77); send(8'h55); send(8'h55); send(8'hAB);
      chk("wr_cyc", {28'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o, 1'b0}, 32'hE);
      chk("wr_sel", {28'd0, wbm_sel_o}, 32'hF);
      chk("wr_adr", wbm_adr_o, 32'h0000_0110);
      chk("wr_dat", wbm_dat_o, 32'h7755_55AB);
      wait_idle("wr_idle");
      chk("wr_nlog", n_log, 1);
      chk("wr_log_adr", log_adr[0], 32'h0000_0110);
      chk("wr_log_dat", log_dat[0], 32'h7755_55AB);
      chk("wr_log_we", {31'd0, log_we[0]}, 32'd1);
      chk("wr_err", {31'd0, err}, 32'd0);

      // single-word read with tx back-pressure on byte 2
      rd_q[0] = 32'h7755_55AB;
      send(8'h02); send(8'h01); send(8'h00); send(8'h00); send(8'h01); send(8'h10);
      recv("rd_b0", 8'h77, 0);
      recv("rd_b1", 8'h55, 10);
      recv("rd_b2", 8'h55, 0);
      recv("rd_b3", 8'hAB, 0);
      chk("rd_busy_after", {31'd0, busy}, 32'd0);
      chk("rd_log_adr", log_adr[1], 32'h0000_0110);
      chk("rd_log_we", {31'd0, log_we[1]}, 32'd0);
      chk("rd_log_sel", {28'd0, log_sel[1]}, 32'hF);
      chk("rd_err", {31'd0, err}, 32'd0);

      // two-word write wrapping past the top of the address space
      send(8'h01); send(8'h02); send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFC);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      wait_cyc_done();
      chk("wrap_mid_busy", {31'd0, busy}, 32'd1);
      send(8'h55); send(8'h66); send(8'h77); send(8'h88);
      wait_idle("wrap_wr_idle");
      chk("wrap_nlog", n_log, 4);
      chk("wrap_adr0", log_adr[2], 32'hFFFF_FFFC);
      chk("wrap_dat0", log_dat[2], 32'h1122_3344);
      chk("wrap_adr1", log_adr[3], 32'h0000_0000);
      chk("wrap_dat1", log_dat[3], 32'h5566_7788);

      // two-word read over the same wrap
      rd_q[1] = 32'hA1B2_C3D4;
      rd_q[2] = 32'h0F1E_2D3C;
      send(8'h02); send(8'h02); send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFC);
      recv("rr_b0", 8'hA1, 0); recv("rr_b1", 8'hB2, 0);
      recv("rr_b2", 8'hC3, 0); recv("rr_b3", 8'hD4, 0);
      recv("rr_b4", 8'h0F, 0); recv("rr_b5", 8'h1E, 0);
      recv("rr_b6", 8'h2D, 0); recv("rr_b7", 8'h3C, 0);
      chk("rr_busy", {31'd0, busy}, 32'd0);
      chk("rr_adr0", log_adr[4], 32'hFFFF_FFFC);
      chk("rr_adr1", log_adr[5], 32'h0000_0000);

      // junk byte in IDLE, then a read
      send(8'h55);
      chk("junk_busy", {31'd0, busy}, 32'd0);
      rd_q[3] = 32'hDEAD_BEEF;
      send(8'h02); send(8'h01); send(8'h00); send(8'h00); send(8'h00); send(8'h20);
      recv("jk_b0", 8'hDE, 0); recv("jk_b1", 8'hAD, 0);
      recv("jk_b2", 8'hBE, 0); recv("jk_b3", 8'hEF, 0);
      chk("jk_adr", log_adr[6], 32'h0000_0020);
      chk("jk_err", {31'd0, err}, 32'd0);

      // gap timer: byte on the limit cycle survives, full gap aborts
      send(8'h01); send(8'h01); send(8'h00);
      repeat (39) tick();
      chk("gap_edge_busy", {31'd0, busy}, 32'd1);
      send(8'h00);
      chk("gap_win_busy", {31'd0, busy}, 32'd1);
      chk("gap_win_err", {31'd0, err}, 32'd0);
      repeat (39) tick();
      chk("gap_39_busy", {30'd0, busy, err}, 32'h2);
      tick();
      chk("gap_abort", {30'd0, busy, err}, 32'h1);
      chk("gap_nlog", n_log, 7);

      // overrun during WB_RD, then reset with the cycle in flight
      slave_en = 1'b0;
      send(8'h02); send(8'h01); send(8'h00); send(8'h00); send(8'h00); send(8'h40);
      chk("ovr_cyc", {31'd0, wbm_cyc_o}, 32'd1);
      send(8'h99);
      chk("ovr_state", {30'd0, wbm_cyc_o, busy}, 32'h3);
      resetn = 1'b0;
      tick();
      chk("mid_rst_wb", {26'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o[0], tx_valid, busy}, 32'd0);
      chk("mid_rst_err", {31'd0, err}, 32'd0);
      chk("mid_rst_adr", wbm_adr_o, 32'd0);
      chk("mid_rst_tx", {24'd0, tx_data}, 32'd0);
      resetn = 1'b1;
      tick();

`ifdef DBG_WB_TIMEOUT_EN
      begin
         int k = 0;
         send(8'h02); send(8'h01); send(8'h00); send(8'h00); send(8'h00); send(8'h30);
         while (wbm_cyc_o && k < 2000) begin
            tick();
            k++;
         end
         chk("to_cyc_len", k, 1024);
         recv("to_b0", 8'hFF, 0); recv("to_b1", 8'hFF, 0);
         recv("to_b2", 8'hFF, 0); recv("to_b3", 8'hFF, 0);
         chk("to_busy", {31'd0, busy}, 32'd0);
         chk("to_err", {31'd0, err}, 32'd1);
      end
`endif
      slave_en = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dbg_uart_wb_ctrl.md
Name: dbg_uart_wb_ctrl

Overview:
Command sequencer for the UART debug port of the management SoC. Takes received bytes from the UART RX byte interface and parses the debug protocol: cmd, size, 4 address bytes MSB-first, then data. Issues Wishbone classic master cycles and streams read data back through the UART TX byte interface. Sits between the debug UART and the Wishbone interconnect as an additional bus master.

Parameters:
RX_GAP_CYCLES, 32'd200000, idle cycles allowed between bytes of one command before abort
WB_TIMEOUT_CYCLES, 16'd1024, max cycles waiting for wbm_ack_i (used only with optional feature)

Ports:
clk  input  1  system clock
resetn  input  1  synchronous active-low reset
rx_data  input  8  received byte
rx_valid  input  1  one-cycle strobe, rx_data valid
tx_data  output  8  byte to transmit
tx_valid  output  1  tx_data valid; held until tx_ready
tx_ready  input  1  UART TX accepts byte when tx_valid&&tx_ready
wbm_adr_o  output  32  byte address
wbm_dat_o  output  32  write data
wbm_dat_i  input  32  read data
wbm_we_o  output  1  write enable
wbm_sel_o  output  4  always 4'hF while cyc asserted
wbm_stb_o  output  1  strobe
wbm_cyc_o  output  1  cycle
wbm_ack_i  input  1  acknowledge
busy  output  1  high whenever state != IDLE
err  output  1  sticky: overrun, gap abort or bus timeout; cleared only by reset

Behaviour:
- Reset (resetn=0 at posedge clk, any state): state=IDLE; all outputs 0; byte/word counters, address, data and gap counter cleared. An in-flight Wishbone cycle is dropped the same edge.
- Commands: 8'h01 write, 8'h02 read; any other byte in IDLE is discarded and the state stays IDLE.
- States: IDLE -> SIZE -> ADDR (4 bytes) -> write: WDATA (4 bytes) -> WB_WR -> WDATA or IDLE; read: WB_RD -> TX (4 bytes) -> WB_RD or IDLE.
- SIZE byte N = word count. N=0 completes after address with no bus cycle.
- Address assembled big-endian. wbm_adr_o increments by 4 after each word; wraps at 32 bits.
- Write data is assembled big-endian (first byte = bits 31:24). WB_WR begins the cycle after the 4th data byte.
- Wishbone: cyc=stb=1 with adr/dat/we stable until the first cycle ack=1. Cyc and stb deassert on the next edge. One word per cycle, no pipelining.
- Read: wbm_dat_i is latched on ack. TX sends bytes 31:24 first. Each byte is presented with tx_valid=1 until tx_ready; the next byte is presented the cycle after acceptance. The next word's WB_RD starts after the 4th byte is accepted.
- rx_valid in WB_WR, WB_RD or TX: byte dropped, err set, state unaffected.
- Gap timer runs in SIZE, ADDR and WDATA; cleared on each rx_valid. Reaching RX_GAP_CYCLES sets err and goes to IDLE (no bus cycle for the partial word).
- rx_valid on the same cycle the gap limit is reached: the byte wins, the timer clears and there is no abort.
- busy falls the cycle after the final ack (write) or final tx handshake (read).

Optional Feature:
Macro DBG_WB_TIMEOUT_EN.
- Defined: a counter runs while cyc=1. At WB_TIMEOUT_CYCLES without ack, cyc/stb drop, err is set, and the word is treated as complete. Read data returned is 32'hFFFF_FFFF; the sequence then continues normally.
- Undefined: the block waits for ack indefinitely and the counter logic is absent.

Decomposition:
- Package dbg_uart_wb_pkg: state enum (IDLE, SIZE, ADDR, WDATA, WB_WR, WB_RD, TX); CMD_WRITE=8'h01; CMD_READ=8'h02; TIMEOUT_RDATA=32'hFFFF_FFFF.
- Sub-module dbg_byte_pack: 4-byte big-endian shift-in/shift-out register with 2-bit byte counter. Instantiated once for address and once for data.

Test Plan:
- Bytes 01,01,00,00,01,10,77,55,55,AB -> one WB write, adr=32'h00000110, dat=32'h775555AB, sel=F; busy low after ack; err=0.
- Bytes 02,01,00,00,01,10 with slave returning 32'h775555AB -> tx sequence 77,55,55,AB; tx_ready held low 10 cycles on byte 2 keeps tx_data=55 stable.
- Write N=2 at 32'hFFFFFFFC -> writes at FFFFFFFC then 00000000 (wrap); read N=2 returns both words (8 tx bytes) in order.
- Byte 55 in IDLE followed by a valid read -> 55 ignored, read executes, err=0.
- Bytes 01,01,00 then silence for RX_GAP_CYCLES -> err=1, IDLE, no cyc; resetn low mid-WB_RD -> cyc=0 and all outputs 0 next edge.
- With DBG_WB_TIMEOUT_EN and a slave that never acks a read -> cyc drops after 1024 cycles, tx sends FF,FF,FF,FF, err=1.
